audio_fm_ctrl: RTL and testbench

//  Parametrised successor to the two-channel audio handler that feeds the FM modulator.

---
 rtl/audio_fm_pkg.sv | 23 ++
 rtl/fm_gain_ramp.sv | 54 +++++
 rtl/audio_fm_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_audio_fm_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fm_pkg.sv
// Shared definitions for the FM audio front end: state encoding,
// default carrier tuning and the offset-binary midscale helper.
package audio_fm_pkg;

    // Control states of the channel / mute sequencer.
    typedef enum logic [2:0] {
        FADE_IN  = 3'd0,
        RUN      = 3'd1,
        FADE_OUT = 3'd2,
        RETUNE   = 3'd3,
        MUTED    = 3'd4
    } fm_state_t;

    // Default carrier word for channel 0 and the spacing between channels.
    localparam logic [31:0] DEF_FRE_BASE = 32'd4166;
    localparam logic [31:0] DEF_FRE_STEP = 32'd86;

    // Midscale of an offset-binary sample of the given width (2^(width-1)).
    function automatic int unsigned mid_of(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fm_gain_ramp.sv
// Gain ramp for click-free fades: a prescaler divides the clock by RAMP_DIV
// and each prescaler wrap moves the gain one step toward 0 or full scale.
module fm_gain_ramp #(
    parameter int GAIN_W   = 4,
    parameter int RAMP_DIV = 256
) (
    input  logic            clk_in,
    input  logic            RST,
    input  logic            dir,
    input  logic            clr_pre,
    output logic [GAIN_W:0] gain,
    output logic            at_min,
    output logic            at_max
);

    localparam int              PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [GAIN_W:0]  GAIN_MAX = {1'b1, {GAIN_W{1'b0}}};

    logic [PRE_W-1:0] r_pre;
    logic [GAIN_W:0]  r_gain;
    logic [PRE_W-1:0] w_pre_eff;
    logic             w_wrap;

    // A pending clear makes the current cycle count as the first of a fresh
    // period, so a new state always gets a full RAMP_DIV before its first step
    // without losing a cycle when RAMP_DIV is 1.
    assign w_pre_eff = clr_pre ? '0 : r_pre;
    assign w_wrap    = (w_pre_eff == PRE_LAST);

    assign at_min = (r_gain == '0);
    assign at_max = (r_gain == GAIN_MAX);
    assign gain   = r_gain;

    // Prescaler and saturating gain counter, stepping once per prescaler wrap.
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            r_pre  <= '0;
            r_gain <= '0;
        end else begin
            if (w_wrap) begin
                r_pre <= '0;
                if (dir && !at_max) begin
                    r_gain <= r_gain + (GAIN_W+1)'(1);
                end else if (!dir && !at_min) begin
                    r_gain <= r_gain - (GAIN_W+1)'(1);
                end
            end else begin
                r_pre <= w_pre_eff + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/audio_fm_ctrl.sv
// Audio source selector for the FM modulator. Routes one of NUM_CH offset-binary
// inputs through a gain-scaled pipeline to Module_SIG and owns the carrier word.
// Channel switches and mute fade to silence first, so the carrier is only
// retuned while the gain is zero.
module audio_fm_ctrl
    import audio_fm_pkg::*;
#(
    parameter int                     NUM_CH      = 4,
    parameter int                     IN_WIDTH    = 12,
    parameter int                     PHASE_WIDTH = 32,
    parameter int                     GAIN_W      = 4,
    parameter int                     RAMP_DIV    = 256,
    parameter logic [PHASE_WIDTH-1:0] FRE_BASE    = PHASE_WIDTH'(DEF_FRE_BASE),
    parameter logic [PHASE_WIDTH-1:0] FRE_STEP    = PHASE_WIDTH'(DEF_FRE_STEP)
) (
    input  logic                       clk_in,
    input  logic                       RST,
    input  logic [NUM_CH*IN_WIDTH-1:0] audio_in,
    input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
    input  logic                       sel_valid,
    output logic                       sel_ready,
    output logic                       sel_err,
    input  logic                       mute,
    output logic [$clog2(NUM_CH)-1:0]  ch_cur,
    output logic [IN_WIDTH-1:0]        Module_SIG,
    output logic [PHASE_WIDTH-1:0]     Fre_word
);

    localparam int                CH_W     = $clog2(NUM_CH);
    localparam logic [IN_WIDTH-1:0] MID    = IN_WIDTH'(mid_of(IN_WIDTH));
    localparam logic [CH_W:0]     NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam int                PROD_W   = IN_WIDTH + GAIN_W + 2;

    fm_state_t                r_state;
    logic [CH_W-1:0]          r_ch_cur;
    logic [CH_W-1:0]          r_pend_ch;
    logic                     r_pend;
    logic [PHASE_WIDTH-1:0]   r_fre;
    logic                     r_sel_ready;
    logic                     r_sel_err;
    logic                     r_clr_pre;
    logic signed [IN_WIDTH:0] r_s1;
    logic [IN_WIDTH-1:0]      r_sig;

    logic [GAIN_W:0]          w_gain;
    logic                     w_at_min;
    logic                     w_at_max;
    logic                     w_dir;
    logic                     w_accept;
    logic                     w_sel_bad;
    logic                     w_sel_new;
    logic [IN_WIDTH-1:0]      w_sample;
    logic signed [PROD_W-1:0] w_s1_ext;
    logic signed [PROD_W-1:0] w_gain_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_scaled;
    logic [PHASE_WIDTH-1:0]   w_retune_word;

    // Gain ramps up while fading in (unless mute cuts in) and is held at full
    // scale in RUN; everywhere else it ramps down or stays parked at zero.
    assign w_dir = ((r_state == FADE_IN) && !mute) || (r_state == RUN);

    fm_gain_ramp #(
        .GAIN_W   (GAIN_W),
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp (
        .clk_in  (clk_in),
        .RST     (RST),
        .dir     (w_dir),
        .clr_pre (r_clr_pre),
        .gain    (w_gain),
        .at_min  (w_at_min),
        .at_max  (w_at_max)
    );

    assign w_accept      = sel_valid && r_sel_ready;
    assign w_sel_bad     = ({1'b0, ch_sel} >= NUM_CH_L);
    assign w_sel_new     = w_accept && !w_sel_bad && (ch_sel != r_ch_cur);
    assign w_retune_word = FRE_BASE + PHASE_WIDTH'(r_pend_ch) * FRE_STEP;

    // Channel mux: picks the sample of the currently routed channel.
    always_comb begin
        w_sample = audio_in[IN_WIDTH-1:0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch_cur == CH_W'(k)) begin
                w_sample = audio_in[k*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // Signed product of centred sample and gain; floor shift back to sample scale.
    // |s1| <= MID and gain <= 2^GAIN_W, so the scaled value always fits the sample range.
    assign w_s1_ext   = {{(PROD_W-IN_WIDTH-1){r_s1[IN_WIDTH]}}, r_s1};
    assign w_gain_ext = $signed({{(PROD_W-GAIN_W-1){1'b0}}, w_gain});
    assign w_prod     = w_s1_ext * w_gain_ext;
    assign w_scaled   = w_prod >>> GAIN_W;

    // Two-stage datapath: centre the sample, then scale by the live gain and re-offset.
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            r_s1  <= '0;
            r_sig <= MID;
        end else begin
            r_s1  <= $signed({1'b0, w_sample}) - $signed({1'b0, MID});
            r_sig <= MID + w_scaled[IN_WIDTH-1:0];
        end
    end

    // Sequencer: fades around channel switches and mute, retunes only at zero gain.
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            r_state     <= FADE_IN;
            r_ch_cur    <= '0;
            r_pend_ch   <= '0;
            r_pend      <= 1'b0;
            r_fre       <= FRE_BASE;
            r_sel_ready <= 1'b0;
            r_sel_err   <= 1'b0;
            r_clr_pre   <= 1'b0;
        end else begin
            r_sel_err <= 1'b0;
            r_clr_pre <= 1'b0;
            case (r_state)
                FADE_IN: begin
                    if (mute) begin
                        r_pend    <= 1'b0;
                        r_state   <= FADE_OUT;
                        r_clr_pre <= 1'b1;
                    end else if (w_at_max) begin
                        r_state     <= RUN;
                        r_sel_ready <= 1'b1;
                        r_clr_pre   <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept && w_sel_bad) begin
                        r_sel_err <= 1'b1;
                    end
                    if (w_sel_new) begin
                        r_pend_ch   <= ch_sel;
                        r_pend      <= 1'b1;
                        r_state     <= FADE_OUT;
                        r_sel_ready <= 1'b0;
                        r_clr_pre   <= 1'b1;
                    end else if (mute) begin
                        r_pend      <= 1'b0;
                        r_state     <= FADE_OUT;
                        r_sel_ready <= 1'b0;
                        r_clr_pre   <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (w_at_min) begin
                        r_clr_pre <= 1'b1;
                        if (r_pend) begin
                            r_state     <= RETUNE;
                            r_sel_ready <= 1'b0;
                        end else begin
                            r_state     <= MUTED;
                            r_sel_ready <= 1'b1;
                        end
                    end
                end
                RETUNE: begin
                    r_ch_cur  <= r_pend_ch;
                    r_fre     <= w_retune_word;
                    r_pend    <= 1'b0;
                    r_clr_pre <= 1'b1;
                    if (mute) begin
                        r_state     <= MUTED;
                        r_sel_ready <= 1'b1;
                    end else begin
                        r_state     <= FADE_IN;
                        r_sel_ready <= 1'b0;
                    end
                end
                MUTED: begin
                    if (w_accept && w_sel_bad) begin
                        r_sel_err <= 1'b1;
                    end
                    if (w_sel_new) begin
                        r_pend_ch   <= ch_sel;
                        r_pend      <= 1'b1;
                        r_state     <= RETUNE;
                        r_sel_ready <= 1'b0;
                        r_clr_pre   <= 1'b1;
                    end else if (!mute) begin
                        r_state     <= FADE_IN;
                        r_sel_ready <= 1'b0;
                        r_clr_pre   <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= FADE_IN;
                    r_pend      <= 1'b0;
                    r_sel_ready <= 1'b0;
                    r_clr_pre   <= 1'b1;
                end
            endcase
        end
    end

    assign sel_ready  = r_sel_ready;
    assign sel_err    = r_sel_err;
    assign ch_cur     = r_ch_cur;
    assign Module_SIG = r_sig;
    assign Fre_word   = r_fre;

endmodule

// File: tb/tb_audio_fm_ctrl.sv
// Directed bench for audio_fm_ctrl: a four-channel instance walks through ramp,
// channel switch, mute and reset-abort; a three-channel instance covers the
// out-of-range select and same-channel no-op.
module tb_audio_fm_ctrl;

    localparam int IN_W = 12;

    logic clk_in = 1'b0;
    logic RST;

    logic [4*IN_W-1:0] audio4;
    logic [1:0]        sel4;
    logic              valid4;
    logic              mute4;
    logic              rdy4;
    logic              err4;
    logic [1:0]        cur4;
    logic [IN_W-1:0]   sig4;
    logic [31:0]       fre4;

    logic [3*IN_W-1:0] audio3;
    logic [1:0]        sel3;
    logic              valid3;
    logic              mute3;
    logic              rdy3;
    logic              err3;
    logic [1:0]        cur3;
    logic [IN_W-1:0]   sig3;
    logic [31:0]       fre3;

    int assertCount;
    int failCount;

    always #5 clk_in = ~clk_in;

    audio_fm_ctrl #(
        .NUM_CH      (4),
        .IN_WIDTH    (IN_W),
        .PHASE_WIDTH (32),
        .GAIN_W      (4),
        .RAMP_DIV    (1),
        .FRE_BASE    (32'd1000),
        .FRE_STEP    (32'd100)
    ) u_dut (
        .clk_in     (clk_in),
        .RST        (RST),
        .audio_in   (audio4),
        .ch_sel     (sel4),
        .sel_valid  (valid4),
        .sel_ready  (rdy4),
        .sel_err    (err4),
        .mute       (mute4),
        .ch_cur     (cur4),
        .Module_SIG (sig4),
        .Fre_word   (fre4)
    );

    audio_fm_ctrl #(
        .NUM_CH      (3),
        .IN_WIDTH    (IN_W),
        .PHASE_WIDTH (32),
        .GAIN_W      (4),
        .RAMP_DIV    (1),
        .FRE_BASE    (32'd1000),
        .FRE_STEP    (32'd100)
    ) u_dut3 (
        .clk_in     (clk_in),
        .RST        (RST),
        .audio_in   (audio3),
        .ch_sel     (sel3),
        .sel_valid  (valid3),
        .sel_ready  (rdy3),
        .sel_err    (err3),
        .mute       (mute3),
        .ch_cur     (cur3),
        .Module_SIG (sig3),
        .Fre_word   (fre3)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // One-cycle channel request on the four-channel instance.
    task automatic applyStimulus(input logic [1:0] ch);
        sel4   = ch;
        valid4 = 1'b1;
        tick(1);
        valid4 = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        RST    = 1'b1;
        audio4 = {12'd2548, 12'd1648, 12'd1048, 12'd3048};
        audio3 = {12'd2048, 12'd2048, 12'd3048};
        sel4 = 2'd0; valid4 = 1'b0; mute4 = 1'b0;
        sel3 = 2'd0; valid3 = 1'b0; mute3 = 1'b0;

        tick(3);
        checkOutput("rst_sig", 32'(sig4), 2048);
        checkOutput("rst_fre", fre4, 1000);
        checkOutput("rst_cur", 32'(cur4), 0);
        checkOutput("rst_rdy", 32'(rdy4), 0);
        checkOutput("rst_err", 32'(err4), 0);
        checkOutput("rst_rdy3", 32'(rdy3), 0);
        RST = 1'b0;

        // Fade in on ch0 (s1=+1000): one gain step per clock.
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            checkOutput("ramp_sig", 32'(sig4), 32'(2048 + (1000 * (k - 1)) / 16));
            checkOutput("ramp_fre", fre4, 1000);
            checkOutput("ramp_rdy", 32'(rdy4), (k == 17) ? 32'd1 : 32'd0);
        end

        // Two-cycle datapath latency at full gain.
        audio4[11:0] = 12'd1048;
        tick(1);
        checkOutput("lat_hold", 32'(sig4), 3048);
        tick(1);
        checkOutput("lat_step", 32'(sig4), 1048);

        // Switch to ch1: fade out, retune at zero gain, fade back in.
        applyStimulus(2'd1);
        checkOutput("sw_rdy_low", 32'(rdy4), 0);
        checkOutput("sw_cur_old", 32'(cur4), 0);
        checkOutput("sw_fre_old", fre4, 1000);
        tick(9);
        checkOutput("sw_mid_fade", 32'(sig4), 1548);
        tick(8);
        checkOutput("sw_pre_fre", fre4, 1000);
        checkOutput("sw_pre_cur", 32'(cur4), 0);
        checkOutput("sw_pre_sig", 32'(sig4), 2048);
        tick(1);
        checkOutput("sw_fre_new", fre4, 1100);
        checkOutput("sw_cur_new", 32'(cur4), 1);
        checkOutput("sw_sig_mid", 32'(sig4), 2048);
        tick(2);
        checkOutput("sw_floor", 32'(sig4), 1985);
        tick(15);
        checkOutput("sw_final_sig", 32'(sig4), 1048);
        checkOutput("sw_final_rdy", 32'(rdy4), 1);

        // Same-channel request is a no-op.
        applyStimulus(2'd1);
        checkOutput("noop_rdy", 32'(rdy4), 1);
        checkOutput("noop_err", 32'(err4), 0);
        checkOutput("noop_fre", fre4, 1100);
        checkOutput("noop_cur", 32'(cur4), 1);
        tick(1);
        checkOutput("noop_sig", 32'(sig4), 1048);

        // Three-channel instance: same-channel no-op, then ch_sel=3 is invalid.
        sel3 = 2'd0; valid3 = 1'b1;
        tick(1);
        checkOutput("n3_noop_err", 32'(err3), 0);
        checkOutput("n3_noop_rdy", 32'(rdy3), 1);
        checkOutput("n3_noop_fre", fre3, 1000);
        sel3 = 2'd3;
        tick(1);
        valid3 = 1'b0;
        checkOutput("n3_err_pulse", 32'(err3), 1);
        checkOutput("n3_err_rdy", 32'(rdy3), 1);
        tick(1);
        checkOutput("n3_err_clear", 32'(err3), 0);
        checkOutput("n3_rdy_after", 32'(rdy3), 1);
        checkOutput("n3_cur", 32'(cur3), 0);
        checkOutput("n3_fre", fre3, 1000);
        checkOutput("n3_sig", 32'(sig3), 3048);

        // Switch to ch3, then mute at gain 10 during the fade-in.
        applyStimulus(2'd3);
        checkOutput("m_rdy_low", 32'(rdy4), 0);
        tick(17);
        checkOutput("m_fre_old", fre4, 1100);
        checkOutput("m_cur_old", 32'(cur4), 1);
        tick(1);
        checkOutput("m_fre_ch3", fre4, 1300);
        checkOutput("m_cur_ch3", 32'(cur4), 3);
        tick(10);
        mute4 = 1'b1;
        tick(1);
        checkOutput("m_sig_g10", 32'(sig4), 2360);
        tick(1);
        checkOutput("m_sig_g9", 32'(sig4), 2329);
        tick(8);
        checkOutput("m_rdy_fading", 32'(rdy4), 0);
        tick(1);
        checkOutput("m_rdy_muted", 32'(rdy4), 1);
        checkOutput("m_sig_muted", 32'(sig4), 2048);

        // Retune to ch2 while muted, then unmute.
        applyStimulus(2'd2);
        checkOutput("mr_rdy_low", 32'(rdy4), 0);
        checkOutput("mr_fre_old", fre4, 1300);
        tick(1);
        checkOutput("mr_fre_new", fre4, 1200);
        checkOutput("mr_cur_new", 32'(cur4), 2);
        checkOutput("mr_rdy_muted", 32'(rdy4), 1);
        checkOutput("mr_sig_mid", 32'(sig4), 2048);
        mute4 = 1'b0;
        tick(1);
        checkOutput("um_rdy_low", 32'(rdy4), 0);
        tick(17);
        checkOutput("um_sig", 32'(sig4), 1648);
        checkOutput("um_rdy", 32'(rdy4), 1);

        // Reset in the middle of a fade-out with ch3 pending.
        applyStimulus(2'd3);
        tick(9);
        checkOutput("ra_pre_fre", fre4, 1200);
        checkOutput("ra_pre_cur", 32'(cur4), 2);
        checkOutput("ra_pre_rdy", 32'(rdy4), 0);
        checkOutput("ra_pre_sig", 32'(sig4), 1848);
        RST = 1'b1;
        #1;
        checkOutput("ra_sig", 32'(sig4), 2048);
        checkOutput("ra_fre", fre4, 1000);
        checkOutput("ra_cur", 32'(cur4), 0);
        checkOutput("ra_rdy", 32'(rdy4), 0);
        checkOutput("ra_err", 32'(err4), 0);
        tick(2);
        RST = 1'b0;
        tick(16);
        checkOutput("rr_rdy_low", 32'(rdy4), 0);
        checkOutput("rr_cur", 32'(cur4), 0);
        checkOutput("rr_fre", fre4, 1000);
        tick(1);
        checkOutput("rr_rdy", 32'(rdy4), 1);
        checkOutput("rr_sig", 32'(sig4), 1048);
        checkOutput("rr_cur_end", 32'(cur4), 0);
        checkOutput("rr_fre_end", fre4, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
